// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the entry/fault types used by the instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_RANGE,
    FC_MISALIGN
  } fault_cause_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of {pc, inst} pairs between the ROM return path and decode.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: PC generation, ROM addressing with 1-cycle return,
// credit-limited buffering toward decode, redirects and sticky fetch faults.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ROM_WORDS = 19,
  parameter int DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] Address,
  input  logic [INST_W-1:0] InstIn,
  input  logic              RedirectValid,
  input  logic [ADDR_W-1:0] RedirectPc,
  output logic              InstValid,
  input  logic              InstReady,
  output logic [ADDR_W-1:0] InstPc,
  output logic [INST_W-1:0] InstOut,
  output logic              Fault,
  output logic [ADDR_W-1:0] FaultPc
);

  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(ROM_WORDS * 4);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_tag;
  logic [ADDR_W-1:0] r_fault_pc;
  logic              r_inflight;
  fault_cause_t      r_cause;

  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_fault;
  logic              w_in_range;
  fetch_entry_t      w_head;
  fetch_entry_t      w_entry;

  assign w_fault    = (r_cause != FC_NONE);
  assign w_in_range = (r_pc < PC_LIMIT);
  assign w_pop      = InstValid & InstReady;
  // Occupancy after this cycle's dequeue; the in-flight word already owns a slot.
  assign w_occ      = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue    = !w_fault && !RedirectValid && w_in_range && (w_occ < 3'(DEPTH));
  assign w_push     = r_inflight && !RedirectValid;
  assign w_entry    = '{pc: r_tag, inst: InstIn};

  // The ROM samples Address on the issue edge, so the new PC is driven during the issue cycle.
  assign Address = w_issue ? r_pc : r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_tag      <= '0;
      r_fault_pc <= '0;
      r_inflight <= 1'b0;
      r_cause    <= FC_NONE;
    end else if (RedirectValid) begin
      r_pc       <= RedirectPc;
      r_inflight <= 1'b0;
      if (RedirectPc[1:0] != 2'b00) begin
        r_cause    <= FC_MISALIGN;
        r_fault_pc <= RedirectPc;
      end else begin
        r_cause <= FC_NONE;
      end
    end else begin
      if (w_issue) begin
        r_pc       <= r_pc + ADDR_W'(4);
        r_addr     <= r_pc;
        r_tag      <= r_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
      if (!w_fault && !w_in_range) begin
        r_cause    <= FC_RANGE;
        r_fault_pc <= r_pc;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (RedirectValid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign InstValid = (w_count != 2'd0);
  assign InstPc    = w_head.pc;
  assign InstOut   = w_head.inst;
  assign Fault     = w_fault;
  assign FaultPc   = r_fault_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle synchronous ROM model.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] InstIn;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] InstPc;
  logic [31:0] InstOut;
  logic        Fault;
  logic [31:0] FaultPc;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rom [32];

  always #5 clk = ~clk;

  always @(posedge clk) InstIn <= rom[Address[6:2]];

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Address       (Address),
    .InstIn        (InstIn),
    .RedirectValid (RedirectValid),
    .RedirectPc    (RedirectPc),
    .InstValid     (InstValid),
    .InstReady     (InstReady),
    .InstPc        (InstPc),
    .InstOut       (InstOut),
    .Fault         (Fault),
    .FaultPc       (FaultPc)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; InstReady = 1'b1; RedirectValid = 1'b0; RedirectPc = '0;
    repeat (2) tick();
    vectors++; if (InstValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", InstValid); end
    vectors++; if (InstPc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", InstPc); end
    vectors++; if (InstOut !== 32'h0) begin miscompares++; $display("FAIL reset_inst got %h want 0", InstOut); end
    vectors++; if (Fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %0b want 0", Fault); end
    vectors++; if (FaultPc !== 32'h0) begin miscompares++; $display("FAIL reset_faultpc got %h want 0", FaultPc); end
    vectors++; if (Address !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", Address); end
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    tick();
    vectors++; if (InstValid !== 1'b0) begin miscompares++; $display("FAIL startup_early got %0b want 0", InstValid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++; if (InstValid !== 1'b1) begin miscompares++; $display("FAIL startup_valid[%0d] got %0b want 1", k, InstValid); end
      vectors++; if (InstPc !== 32'(4*k)) begin miscompares++; $display("FAIL startup_pc[%0d] got %h want %h", k, InstPc, 32'(4*k)); end
      vectors++; if (InstOut !== rom[k]) begin miscompares++; $display("FAIL startup_inst[%0d] got %h want %h", k, InstOut, rom[k]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0; InstReady = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      vectors++; if (InstValid !== 1'b1 || InstPc !== 32'h0 || InstOut !== 32'h00450693)
        begin miscompares++; $display("FAIL hold_head[%0d] got %0b/%h/%h want 1/0/00450693", i, InstValid, InstPc, InstOut); end
      vectors++; if (Address !== 32'h4) begin miscompares++; $display("FAIL hold_addr[%0d] got %h want 4", i, Address); end
      tick();
    end
    InstReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vectors++; if (InstValid !== 1'b1 || InstPc !== 32'(4*k) || InstOut !== rom[k])
        begin miscompares++; $display("FAIL resume[%0d] got %0b/%h/%h want 1/%h/%h", k, InstValid, InstPc, InstOut, 32'(4*k), rom[k]); end
      tick();
    end
  endtask

  task automatic test_redirect();
    RedirectValid = 1'b1; RedirectPc = 32'h24;
    tick();
    RedirectValid = 1'b0;
    vectors++; if (InstValid !== 1'b0) begin miscompares++; $display("FAIL redir_flush1 got %0b want 0", InstValid); end
    tick();
    vectors++; if (InstValid !== 1'b0) begin miscompares++; $display("FAIL redir_flush2 got %0b want 0", InstValid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++; if (InstValid !== 1'b1 || InstPc !== 32'(32'h24 + 4*k) || InstOut !== rom[9+k])
        begin miscompares++; $display("FAIL redir_stream[%0d] got %0b/%h/%h want 1/%h/%h", k, InstValid, InstPc, InstOut, 32'(32'h24 + 4*k), rom[9+k]); end
      tick();
    end
  endtask

  task automatic test_range();
    RedirectValid = 1'b1; RedirectPc = 32'h3C;
    tick();
    RedirectValid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      vectors++; if (InstValid !== 1'b1 || InstPc !== 32'(32'h3C + 4*k) || InstOut !== rom[15+k])
        begin miscompares++; $display("FAIL tail_stream[%0d] got %0b/%h/%h want 1/%h/%h", k, InstValid, InstPc, InstOut, 32'(32'h3C + 4*k), rom[15+k]); end
      if (k == 3) begin
        vectors++; if (Fault !== 1'b1 || FaultPc !== 32'h4C)
          begin miscompares++; $display("FAIL range_fault got %0b/%h want 1/4c", Fault, FaultPc); end
      end
      tick();
    end
    vectors++; if (InstValid !== 1'b0 || Fault !== 1'b1) begin miscompares++; $display("FAIL range_drain got %0b/%0b want 0/1", InstValid, Fault); end
    tick();
    vectors++; if (InstValid !== 1'b0 || Address !== 32'h48) begin miscompares++; $display("FAIL range_halt got %0b/%h want 0/48", InstValid, Address); end
    RedirectValid = 1'b1; RedirectPc = 32'h0;
    tick();
    RedirectValid = 1'b0;
    vectors++; if (Fault !== 1'b0) begin miscompares++; $display("FAIL range_clear got %0b want 0", Fault); end
    tick(); tick();
    vectors++; if (InstValid !== 1'b1 || InstPc !== 32'h0 || InstOut !== 32'h00450693)
      begin miscompares++; $display("FAIL range_restart got %0b/%h/%h want 1/0/00450693", InstValid, InstPc, InstOut); end
  endtask

  task automatic test_misalign();
    RedirectValid = 1'b1; RedirectPc = 32'h1E;
    tick();
    RedirectValid = 1'b0;
    vectors++; if (Fault !== 1'b1 || FaultPc !== 32'h1E) begin miscompares++; $display("FAIL misalign_fault got %0b/%h want 1/1e", Fault, FaultPc); end
    vectors++; if (InstValid !== 1'b0 || Address !== 32'h4) begin miscompares++; $display("FAIL misalign_halt got %0b/%h want 0/4", InstValid, Address); end
    tick(); tick();
    vectors++; if (InstValid !== 1'b0 || Address !== 32'h4 || Fault !== 1'b1)
      begin miscompares++; $display("FAIL misalign_sticky got %0b/%h/%0b want 0/4/1", InstValid, Address, Fault); end
  endtask

  task automatic test_reset_midstream();
    RedirectValid = 1'b1; RedirectPc = 32'h0; InstReady = 1'b0;
    tick();
    RedirectValid = 1'b0;
    repeat (4) tick();
    vectors++; if (InstValid !== 1'b1 || InstPc !== 32'h0) begin miscompares++; $display("FAIL full_before_reset got %0b/%h want 1/0", InstValid, InstPc); end
    rst_n = 1'b0;
    #1;
    vectors++; if (InstValid !== 1'b0 || Fault !== 1'b0) begin miscompares++; $display("FAIL async_reset got %0b/%0b want 0/0", InstValid, Fault); end
    vectors++; if (InstPc !== 32'h0 || InstOut !== 32'h0) begin miscompares++; $display("FAIL async_reset_data got %h/%h want 0/0", InstPc, InstOut); end
    tick();
    rst_n = 1'b1; InstReady = 1'b1;
    tick(); tick();
    vectors++; if (InstValid !== 1'b1 || InstPc !== 32'h0 || InstOut !== 32'h00450693)
      begin miscompares++; $display("FAIL post_reset got %0b/%h/%h want 1/0/00450693", InstValid, InstPc, InstOut); end
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 32'h0;
    rom[0]  = 32'h00450693; rom[1]  = 32'h00100713; rom[2]  = 32'h00b76463;
    rom[3]  = 32'h00000713; rom[4]  = 32'h00d70733; rom[5]  = 32'h00170713;
    rom[6]  = 32'hfee6dce3; rom[7]  = 32'h00e7a023; rom[8]  = 32'h00478793;
    rom[9]  = 32'h01162023; rom[10] = 32'h00a00593; rom[11] = 32'h00b50633;
    rom[12] = 32'h00c62223; rom[13] = 32'h00000013; rom[14] = 32'h00100093;
    rom[15] = 32'h00208113; rom[16] = 32'h00310193; rom[17] = 32'h00418213;
    rom[18] = 32'hfc1ff06f;
    rst_n = 1'b0; InstReady = 1'b1; RedirectValid = 1'b0; RedirectPc = '0;
    @(negedge clk);
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_range();
    test_misalign();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-ROM read interface.
- Generates the program counter, drives the ROM word address, and captures instruction words returned with the ROM's fixed 1-cycle synchronous read latency.
- Presents {pc, inst} pairs to decode over a valid/ready handshake.
- Handles redirects (branch/jump), backpressure and out-of-range fetches.
- Sits between the instruction ROM and the decode stage.

Parameters:
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0, PC after reset.
- ROM_WORDS, 19, number of valid ROM words; legal PCs are 0 to ROM_WORDS*4-4.
- DEPTH, 2, output buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- Address, out, ADDR_W, byte address to the ROM.
- InstIn, in, INST_W, ROM data, valid 1 cycle after the matching Address.
- RedirectValid, in, 1, load new PC this cycle.
- RedirectPc, in, ADDR_W, redirect target.
- InstValid, out, 1, output entry available.
- InstReady, in, 1, decode accepts the entry.
- InstPc, out, ADDR_W, PC of the presented instruction.
- InstOut, out, INST_W, presented instruction.
- Fault, out, 1, fetch halted (out of range or misaligned).
- FaultPc, out, ADDR_W, offending PC.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - PC=RESET_PC, Address=RESET_PC.
  - Buffer empty, in-flight flag clear.
  - InstValid=0, InstPc=0, InstOut=0, Fault=0, FaultPc=0.
- Issue condition, evaluated every cycle: Fault=0, RedirectValid=0, PC in range, and (buffer count + in-flight) < DEPTH after this cycle's dequeue.
  - On issue: Address=PC, in-flight set with tag PC, PC+=4.
  - Without issue: Address holds its last value, and the returned ROM data is ignored.
- Return: a cycle with in-flight set captures {tag, InstIn} into the buffer, then clears in-flight unless a new issue occurs.
- Latency:
  - First reset-release edge issues RESET_PC.
  - InstValid rises 2 cycles after reset release.
  - Steady state: 1 instruction per cycle while InstReady=1.
- Handshake:
  - InstValid = buffer non-empty; InstPc/InstOut show the head entry.
  - Transfer occurs when InstValid and InstReady are both high.
  - Outputs hold stable while InstValid=1 and InstReady=0.
  - Buffer never overflows; the credit check guarantees this.
- Redirect (highest priority):
  - A transfer accepted in the same cycle completes.
  - Then the buffer is flushed and any in-flight return is discarded (the next-cycle capture is suppressed).
  - PC<=RedirectPc, and Fault is cleared.
  - RedirectPc is issued on the following cycle.
  - First post-redirect InstValid appears 2 cycles after the redirect cycle.
- Misaligned redirect (RedirectPc[1:0]!=0): Fault=1, FaultPc=RedirectPc, no issue.
- Out of range (PC >= ROM_WORDS*4 at issue time):
  - No issue; Fault=1, FaultPc=PC.
  - Already-buffered entries still drain normally.
  - Fault is sticky until a legal redirect or reset.
- Simultaneous events: a redirect and an out-of-range PC in the same cycle resolve to the redirect.
- Wrap: PC increments modulo 2^ADDR_W. Out-of-range detection stops it long before wrap.
- Reset mid-operation: all state is discarded immediately, with no partial outputs.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W, INST_W, RESET_PC.
  - Typedef fetch_entry_t {pc, inst}.
  - Typedef for the fault cause: NONE, RANGE, MISALIGN. Debug only; not a port.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head.
- Top level holds PC, in-flight tracking, credit logic and fault logic.

Test Plan:
- Release reset, InstReady=1 -> InstValid high on the 2nd cycle; entries PC 0x0/0x00450693, 0x4/0x00100713, 0x8/0x00b76463 on consecutive cycles.
- InstReady=0 for 6 cycles after the first entry -> head holds 0x0/0x00450693; Address stops advancing once buffer count plus in-flight reaches 2. Raise InstReady -> entries continue in order with no gaps, duplicates or losses.
- Redirect to 0x24 while an entry is in flight -> no stale entry appears; next output is 0x24/0x01162023 exactly 2 cycles after the redirect.
- Redirect to 0x3C, stream to the end -> 0x48/0xfc1ff06f is delivered, then Fault=1 and FaultPc=0x4C; InstValid drops. Redirect to 0x0 -> Fault clears and fetch resumes at 0x00450693.
- Redirect to 0x1E -> Fault=1, FaultPc=0x1E, no Address change, no InstValid.
- Assert rst_n=0 mid-stream with the buffer full -> InstValid=0 and Fault=0 immediately; after release, the first output is 0x0/0x00450693.
